memory_responder: RTL and testbench

//  Synchronous memory target for the MOV/MOC handshake driven by the control unit.

---
 rtl/memory_responder_pkg.sv | 36 +++
 rtl/memory_responder_lane_formatter.sv | 66 ++++++
 rtl/memory_responder.sv | 181 ++++++++++++++++++
 tb/tb_memory_responder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_responder_pkg.sv
// Shared types and constants for the MOV/MOC memory responder.
package memory_responder_pkg;

    // Width of the wait-state counter; supports LATENCY values 0..15.
    localparam int CNT_W = 4;

    // Access direction as driven on the rw input.
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Handshake FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Access size; the reserved code behaves as a word access.
    typedef enum logic [1:0] {
        DL_BYTE = 2'b00,
        DL_HALF = 2'b01,
        DL_WORD = 2'b10,
        DL_RSVD = 2'b11
    } dl_e;

    // Extend a byte to 32 bits, signed or unsigned.
    function automatic logic [31:0] extend8(input logic [7:0] v, input logic s);
        return s ? {{24{v[7]}}, v} : {24'h000000, v};
    endfunction

    // Extend a halfword to 32 bits, signed or unsigned.
    function automatic logic [31:0] extend16(input logic [15:0] v, input logic s);
        return s ? {{16{v[15]}}, v} : {16'h0000, v};
    endfunction

endpackage

// File: rtl/memory_responder_lane_formatter.sv
// Combinational byte-lane steering for the big-endian memory array.
// Lane k of a word always refers to the byte at (aligned base + k), so
// lane 0 is the most significant byte of a word.
module memory_lane_formatter
    import memory_responder_pkg::*;
(
    input  dl_e             i_dl,
    input  logic            i_sig,
    input  logic [1:0]      i_addr_lo,
    input  logic [31:0]     i_wr_data,
    input  logic [3:0][7:0] i_rd_bytes,
    output logic [3:0]      o_wr_en,
    output logic [3:0][7:0] o_wr_bytes,
    output logic [31:0]     o_rd_data
);

    logic [7:0]  w_rd_byte;
    logic [15:0] w_rd_half;
    logic [31:0] w_rd_word;

    // Pick the addressed byte, the addressed halfword (address bit 0
    // ignored) and the whole word out of the four fetched lanes.
    assign w_rd_byte = i_rd_bytes[i_addr_lo];
    assign w_rd_half = {i_rd_bytes[{i_addr_lo[1], 1'b0}], i_rd_bytes[{i_addr_lo[1], 1'b1}]};
    assign w_rd_word = {i_rd_bytes[0], i_rd_bytes[1], i_rd_bytes[2], i_rd_bytes[3]};

    // Write steering: lane enables plus the data byte destined for each lane.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        o_wr_en    = 4'b0000;
        o_wr_bytes = '0;
        case (i_dl)
            DL_BYTE: begin
                for (int k = 0; k < 4; k++) begin
                    o_wr_bytes[k] = i_wr_data[7:0];
                end
                o_wr_en[i_addr_lo] = 1'b1;
            end
            DL_HALF: begin
                o_wr_bytes[0] = i_wr_data[15:8];
                o_wr_bytes[1] = i_wr_data[7:0];
                o_wr_bytes[2] = i_wr_data[15:8];
                o_wr_bytes[3] = i_wr_data[7:0];
                o_wr_en       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                o_wr_bytes[0] = i_wr_data[31:24];
                o_wr_bytes[1] = i_wr_data[23:16];
                o_wr_bytes[2] = i_wr_data[15:8];
                o_wr_bytes[3] = i_wr_data[7:0];
                o_wr_en       = 4'b1111;
            end
        endcase
    end

    // Read formatting: size selection and sign/zero extension.
    always_comb begin
        o_rd_data = w_rd_word;
        case (i_dl)
            DL_BYTE: o_rd_data = extend8(w_rd_byte, i_sig);
            DL_HALF: o_rd_data = extend16(w_rd_half, i_sig);
            default: o_rd_data = w_rd_word;
        endcase
    end

endmodule

// File: rtl/memory_responder.sv
// Synchronous memory target answering the MOV/MOC four-phase handshake.
// A request is captured in IDLE, waits LATENCY cycles, and the access is
// performed on the edge that enters DONE (and raises moc).
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int LATENCY    = 2
) (
    input  logic                  main_clk,
    input  logic                  reset,
    input  logic                  mov,
    input  logic                  rw,
    input  logic                  sig,
    input  logic [1:0]            dl,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           data_in,
    output logic [31:0]           data_out,
    output logic                  moc,
    output logic                  busy
);

    localparam int               DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY);

    state_e                r_state;
    state_e                w_next_state;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      w_next_count;
    logic                  r_armed;

    logic                  r_req_rw;
    logic                  r_req_sig;
    dl_e                   r_req_dl;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic [31:0]           r_req_wdata;

    logic [31:0]           r_data_out;
    logic [7:0]            r_mem [DEPTH];

    logic                  w_capture;
    logic                  w_enter_done;
    logic                  w_acc_rw;
    logic                  w_acc_sig;
    dl_e                   w_acc_dl;
    logic [ADDR_WIDTH-1:0] w_acc_addr;
    logic [31:0]           w_acc_wdata;
    logic [3:0][7:0]       w_rd_bytes;
    logic [3:0][7:0]       w_wr_bytes;
    logic [3:0]            w_wr_en;
    logic [31:0]           w_rd_data;
    logic                  w_mem_we;

    // A new request is taken only in IDLE and only once mov has been seen
    // low since the previous capture (or during reset).
    assign w_capture = (r_state == ST_IDLE) && mov && r_armed;

    // Next-state and wait-counter logic.
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        case (r_state)
            ST_IDLE: begin
                if (w_capture) begin
                    if (LATENCY == 0) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_WAIT;
                        w_next_count = LAT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!mov) begin
                    // Initiator withdrew the request: abandon it uncommitted.
                    w_next_state = ST_IDLE;
                    w_next_count = '0;
                end else if (r_count <= CNT_W'(1)) begin
                    w_next_state = ST_DONE;
                    w_next_count = '0;
                end else begin
                    w_next_count = r_count - CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (!mov) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_count = '0;
            end
        endcase
    end

    assign w_enter_done = (w_next_state == ST_DONE) && (r_state != ST_DONE);

    // With zero wait states the access happens on the capture edge itself,
    // before the request registers are loaded, so use the live inputs then.
    assign w_acc_rw    = (r_state == ST_IDLE) ? rw         : r_req_rw;
    assign w_acc_sig   = (r_state == ST_IDLE) ? sig        : r_req_sig;
    assign w_acc_dl    = (r_state == ST_IDLE) ? dl_e'(dl)  : r_req_dl;
    assign w_acc_addr  = (r_state == ST_IDLE) ? address    : r_req_addr;
    assign w_acc_wdata = (r_state == ST_IDLE) ? data_in    : r_req_wdata;

    // Fetch the four bytes of the aligned word containing the access address.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_rd_bytes[k] = r_mem[{w_acc_addr[ADDR_WIDTH-1:2], 2'(k)}];
        end
    end

    memory_lane_formatter u_lane_formatter (
        .i_dl       (w_acc_dl),
        .i_sig      (w_acc_sig),
        .i_addr_lo  (w_acc_addr[1:0]),
        .i_wr_data  (w_acc_wdata),
        .i_rd_bytes (w_rd_bytes),
        .o_wr_en    (w_wr_en),
        .o_wr_bytes (w_wr_bytes),
        .o_rd_data  (w_rd_data)
    );

    // State register, wait counter and handshake re-arm flag.
    always_ff @(posedge main_clk) begin
        // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_armed <= !mov;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
            if (w_capture) begin
                r_armed <= 1'b0;
            end else if (!mov) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Request capture; contents only matter while a request is in flight.
    always_ff @(posedge main_clk) begin
        if (w_capture) begin
            r_req_rw    <= rw;
            r_req_sig   <= sig;
            r_req_dl    <= dl_e'(dl);
            r_req_addr  <= address;
            r_req_wdata <= data_in;
        end
    end

    // Read data register: changes only when a read completes.
    always_ff @(posedge main_clk) begin
        if (reset) begin
            r_data_out <= '0;
        end else if (w_enter_done && (w_acc_rw == RW_READ)) begin
            r_data_out <= w_rd_data;
        end
    end

    assign w_mem_we = w_enter_done && (w_acc_rw == RW_WRITE) && !reset;

    // Byte array write port; only the enabled lanes are updated.
    always_ff @(posedge main_clk) begin
        // NOTE: the array has no reset so it maps onto RAM and survives a reset pulse.
        if (w_mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (w_wr_en[k]) begin
                    r_mem[{w_acc_addr[ADDR_WIDTH-1:2], 2'(k)}] <= w_wr_bytes[k];
                end
            end
        end
    end

    assign data_out = r_data_out;
    assign moc      = (r_state == ST_DONE);
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: a LATENCY=2 instance driven from a
// vector table plus hand-written handshake sequences, and a LATENCY=0
// instance sharing the request inputs but with its own mov.
module tb_memory_responder;

    logic        main_clk = 1'b0;
    logic        reset;
    logic        mov;
    logic        mov0;
    logic        rw;
    logic        sig;
    logic [1:0]  dl;
    logic [8:0]  address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [31:0] data_out0;
    logic        moc;
    logic        moc0;
    logic        busy;
    logic        busy0;

    int n_vec = 0;
    int n_err = 0;

    always #5 main_clk = ~main_clk;

    memory_responder #(.ADDR_WIDTH(9), .LATENCY(2)) dut (
        .main_clk (main_clk),
        .reset    (reset),
        .mov      (mov),
        .rw       (rw),
        .sig      (sig),
        .dl       (dl),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out),
        .moc      (moc),
        .busy     (busy)
    );

    memory_responder #(.ADDR_WIDTH(9), .LATENCY(0)) dut0 (
        .main_clk (main_clk),
        .reset    (reset),
        .mov      (mov0),
        .rw       (rw),
        .sig      (sig),
        .dl       (dl),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out0),
        .moc      (moc0),
        .busy     (busy0)
    );

    typedef struct {
        logic        rw;
        logic        sig;
        logic [1:0]  dl;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Full four-phase transaction. Inputs are scrambled after the capture
    // edge to show only the captured copy is used.
    task automatic do_op(input bit use0, input string name, input logic rw_i, input logic sig_i,
                         input logic [1:0] dl_i, input logic [8:0] a, input logic [31:0] wd,
                         input int exp_lat, output logic [31:0] dout);
        int edges;
        int seen;
        rw      = rw_i;
        sig     = sig_i;
        dl      = dl_i;
        address = a;
        data_in = wd;
        if (use0) mov0 = 1'b1;
        else      mov  = 1'b1;
        edges = 0;
        seen  = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            @(negedge main_clk);
            edges++;
            if (edges == 1) begin
                check({name, "_busy"}, use0 ? busy0 : busy, 1'b1);
                rw      = ~rw_i;
                sig     = ~sig_i;
                dl      = ~dl_i;
                address = ~a;
                data_in = ~wd;
            end
            if ((use0 ? moc0 : moc) == 1'b1) seen = 1;
        end
        check({name, "_moc_seen"}, seen, 1);
        check({name, "_latency"}, edges, exp_lat);
        dout = use0 ? data_out0 : data_out;
        if (use0) mov0 = 1'b0;
        else      mov  = 1'b0;
        @(negedge main_clk);
        check({name, "_moc_drop"}, use0 ? moc0 : moc, 1'b0);
        check({name, "_busy_drop"}, use0 ? busy0 : busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        int          seen;
        int          hi;

        //             rw    sig   dl     addr    wdata          exp data_out
        vecs[0]  = '{1'b0, 1'b0, 2'b10, 9'h010, 32'hDEADBEEF, 32'h00000000};
        vecs[1]  = '{1'b1, 1'b0, 2'b10, 9'h010, 32'h00000000, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b1, 2'b00, 9'h013, 32'h00000000, 32'hFFFFFFEF};
        vecs[3]  = '{1'b1, 1'b0, 2'b00, 9'h013, 32'h00000000, 32'h000000EF};
        vecs[4]  = '{1'b1, 1'b1, 2'b01, 9'h011, 32'h00000000, 32'hFFFFDEAD};
        vecs[5]  = '{1'b1, 1'b0, 2'b01, 9'h012, 32'h00000000, 32'h0000BEEF};
        vecs[6]  = '{1'b0, 1'b0, 2'b00, 9'h012, 32'hFFFFFF5A, 32'h0000BEEF};
        vecs[7]  = '{1'b1, 1'b0, 2'b10, 9'h010, 32'h00000000, 32'hDEAD5AEF};
        vecs[8]  = '{1'b1, 1'b1, 2'b00, 9'h010, 32'h00000000, 32'hFFFFFFDE};
        vecs[9]  = '{1'b0, 1'b0, 2'b10, 9'h014, 32'h01020304, 32'hFFFFFFDE};
        vecs[10] = '{1'b0, 1'b0, 2'b01, 9'h015, 32'hAAAA8001, 32'hFFFFFFDE};
        vecs[11] = '{1'b1, 1'b0, 2'b10, 9'h017, 32'h00000000, 32'h80010304};
        vecs[12] = '{1'b1, 1'b1, 2'b01, 9'h016, 32'h00000000, 32'h00000304};
        vecs[13] = '{1'b1, 1'b0, 2'b00, 9'h014, 32'h00000000, 32'h00000080};
        vecs[14] = '{1'b1, 1'b1, 2'b11, 9'h016, 32'h00000000, 32'h80010304};
        vecs[15] = '{1'b0, 1'b0, 2'b11, 9'h1FC, 32'h89ABCDEF, 32'h80010304};
        vecs[16] = '{1'b1, 1'b1, 2'b00, 9'h1FF, 32'h00000000, 32'hFFFFFFEF};
        vecs[17] = '{1'b1, 1'b1, 2'b01, 9'h1FC, 32'h00000000, 32'hFFFF89AB};
        vecs[18] = '{1'b1, 1'b1, 2'b00, 9'h1FD, 32'h00000000, 32'hFFFFFFAB};
        vecs[19] = '{1'b0, 1'b0, 2'b10, 9'h020, 32'hCAFEF00D, 32'hFFFFFFAB};
        vecs[20] = '{1'b1, 1'b0, 2'b10, 9'h020, 32'h00000000, 32'hCAFEF00D};

        // Reset with the initiator idle.
        reset   = 1'b1;
        mov     = 1'b0;
        mov0    = 1'b0;
        rw      = 1'b1;
        sig     = 1'b0;
        dl      = 2'b00;
        address = '0;
        data_in = '0;
        repeat (3) @(negedge main_clk);
        check("reset_moc", moc, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_dout", data_out, 32'h0);
        reset = 1'b0;
        @(negedge main_clk);
        check("post_reset_busy", busy, 1'b0);
        check("post_reset_dout0", data_out0, 32'h0);

        // Table: one transaction per vector on the LATENCY=2 instance.
        for (int i = 0; i < 21; i++) begin
            do_op(1'b0, $sformatf("vec%0d", i), vecs[i].rw, vecs[i].sig, vecs[i].dl,
                  vecs[i].addr, vecs[i].wdata, 3, got);
            check($sformatf("vec%0d_dout", i), got, vecs[i].exp_dout);
        end

        // Abort: write withdrawn after one wait cycle must not commit.
        rw      = 1'b0;
        dl      = 2'b10;
        address = 9'h020;
        data_in = 32'h11223344;
        mov     = 1'b1;
        @(negedge main_clk);
        check("abort_busy", busy, 1'b1);
        @(negedge main_clk);
        check("abort_wait_moc", moc, 1'b0);
        mov = 1'b0;
        @(negedge main_clk);
        check("abort_idle_busy", busy, 1'b0);
        hi = 0;
        repeat (3) begin
            @(negedge main_clk);
            if (moc) hi++;
        end
        check("abort_moc_never", hi, 0);
        check("abort_dout_kept", data_out, 32'hCAFEF00D);
        do_op(1'b0, "abort_read", 1'b1, 1'b0, 2'b10, 9'h020, 32'h0, 3, got);
        check("abort_read_dout", got, 32'hCAFEF00D);

        // mov held high after completion: moc holds, no second transaction.
        rw      = 1'b1;
        sig     = 1'b0;
        dl      = 2'b00;
        address = 9'h021;
        mov     = 1'b1;
        seen    = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            @(negedge main_clk);
            if (moc) seen = 1;
        end
        check("hold_moc_seen", seen, 1);
        check("hold_dout", data_out, 32'h000000FE);
        hi = 0;
        repeat (5) begin
            @(negedge main_clk);
            if (moc) hi++;
        end
        check("hold_moc_stays", hi, 5);
        mov = 1'b0;
        @(negedge main_clk);
        check("hold_release_moc", moc, 1'b0);
        do_op(1'b0, "toggle_read", 1'b1, 1'b1, 2'b00, 9'h022, 32'h0, 3, got);
        check("toggle_read_dout", got, 32'hFFFFFFF0);

        // Reset during the wait of a write, with mov still high.
        rw      = 1'b0;
        dl      = 2'b10;
        address = 9'h020;
        data_in = 32'h55667788;
        mov     = 1'b1;
        @(negedge main_clk);
        check("rst_wait_busy", busy, 1'b1);
        reset = 1'b1;
        @(negedge main_clk);
        check("rst_moc", moc, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_dout", data_out, 32'h0);
        reset = 1'b0;
        hi = 0;
        repeat (3) begin
            @(negedge main_clk);
            if (busy) hi++;
        end
        check("rst_no_retrigger", hi, 0);
        mov = 1'b0;
        @(negedge main_clk);
        do_op(1'b0, "rst_read", 1'b1, 1'b0, 2'b10, 9'h020, 32'h0, 3, got);
        check("rst_read_dout", got, 32'hCAFEF00D);

        // Zero-wait-state instance: moc after the capture edge.
        do_op(1'b1, "l0_write", 1'b0, 1'b0, 2'b10, 9'h040, 32'h0BADF00D, 1, got);
        check("l0_write_dout", got, 32'h0);
        do_op(1'b1, "l0_read", 1'b1, 1'b0, 2'b10, 9'h040, 32'h0, 1, got);
        check("l0_read_dout", got, 32'h0BADF00D);
        do_op(1'b1, "l0_half", 1'b1, 1'b1, 2'b01, 9'h042, 32'h0, 1, got);
        check("l0_half_dout", got, 32'hFFFFF00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
